// File: rtl/bus_cycle_ctrl.sv
// One CPU memory cycle through addr_decode: latch the region nibble, hold the decoder
// enable, drive the oe_n/we_n strobes and stretch the access phase for slow regions or wait_ext.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no cycle in progress; rdy high, req sampled every edge
// S_SETUP  | decoder enabled, strobes inactive, counting setup clocks
// S_ACCESS | strobe active, counting slow-region waits, held by wait_ext
// S_HOLD   | strobe released, decoder still enabled for hold clocks
module bus_cycle_ctrl #(
  parameter int          SETUP_CYCLES = 1,
  parameter int          WAIT_SLOW    = 3,
  parameter int          HOLD_CYCLES  = 1,
  parameter logic [15:0] SLOW_MASK    = 16'h8000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [3:0] cpu_addr,
  input  logic       cpu_rw,
  input  logic       wait_ext,
  input  logic [7:0] rd_data_in,
  output logic       dec_enable,
  output logic [3:0] dec_addr,
  output logic       oe_n,
  output logic       we_n,
  output logic       rdy,
  output logic       done,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_t;

  localparam logic [3:0] L_SETUP_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] L_WAIT_LD  = 4'(WAIT_SLOW);
  localparam logic [3:0] L_HOLD_LD  = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_slow, w_slow_nxt;
  logic [3:0] w_addr_nxt;
  logic       w_en_nxt, w_oe_nxt, w_we_nxt, w_rdy_nxt, w_done_nxt;
  logic [7:0] w_rd_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_rw       <= 1'b0;
      r_slow     <= 1'b0;
      dec_addr   <= 4'd0;
      dec_enable <= 1'b0;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      rdy        <= 1'b1;
      done       <= 1'b0;
      rd_data    <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rw       <= w_rw_nxt;
      r_slow     <= w_slow_nxt;
      dec_addr   <= w_addr_nxt;
      dec_enable <= w_en_nxt;
      oe_n       <= w_oe_nxt;
      we_n       <= w_we_nxt;
      rdy        <= w_rdy_nxt;
      done       <= w_done_nxt;
      rd_data    <= w_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rw_nxt    = r_rw;
    w_slow_nxt  = r_slow;
    w_addr_nxt  = dec_addr;
    w_en_nxt    = dec_enable;
    w_oe_nxt    = oe_n;
    w_we_nxt    = we_n;
    w_rdy_nxt   = rdy;
    w_done_nxt  = 1'b0;
    w_rd_nxt    = rd_data;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_addr_nxt  = cpu_addr;
          w_rw_nxt    = cpu_rw;
          w_slow_nxt  = SLOW_MASK[cpu_addr];
          w_en_nxt    = 1'b1;
          w_rdy_nxt   = 1'b0;
          w_cnt_nxt   = L_SETUP_LD;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_cnt_nxt   = r_slow ? L_WAIT_LD : 4'd0;
          w_oe_nxt    = ~r_rw;
          w_we_nxt    = r_rw;
          w_state_nxt = S_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACCESS: begin
        // wait_ext freezes both the counter and the state
        if (!wait_ext) begin
          if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_oe_nxt = 1'b1;
            w_we_nxt = 1'b1;
            if (r_rw) w_rd_nxt = rd_data_in;
            if (HOLD_CYCLES > 0) begin
              w_cnt_nxt   = L_HOLD_LD;
              w_state_nxt = S_HOLD;
            end else begin
              w_en_nxt    = 1'b0;
              w_rdy_nxt   = 1'b1;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_en_nxt    = 1'b0;
          w_rdy_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
